tff_counter_ctrl: RTL and testbench
===================================

// Module: tff_counter_ctrl
// PURPOSE
//   Controller that sequences a bank of WIDTH T flip-flop cells as a programmable mod-(M+1) up/down counter.
//   Each cycle it computes the per-bit toggle vector t_vec. The cells toggle on posedge clk wherever t_vec[i]=1.
//   Also supports a synchronous parallel load through a valid/ready handshake.
//   Sits between control logic (enable, direction, modulus, load) and the T-FF datapath. Sole driver of every cell's T input.
// PARAMETERS
//   WIDTH     4   counter / T-FF bank width in bits (>=2)
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous reset, active-low
//   en          in   1      count enable
//   up_dn       in   1      1 = count up, 0 = count down
//   modulus     in   WIDTH  terminal value M; count range 0..M
//   load_valid  in   1      load request
//   load_data   in   WIDTH  value to load
//   load_ready  out  1      controller can accept a load
//   q           out  WIDTH  T-FF bank outputs
//   tc          out  1      terminal count (combinational)
//   busy        out  1      high while in LOAD state
// BEHAVIOUR
//   Reset (rst_n=0, async): q=0, state=IDLE, load register=0, tc=0, busy=0, load_ready=1.
//   States:
//     IDLE   hold; t_vec=0
//     COUNT  counting
//     LOAD   apply the load
//   Transitions:
//     IDLE->COUNT on en. COUNT->IDLE on !en.
//     IDLE/COUNT->LOAD on accept.
//     LOAD->COUNT if en, else ->IDLE.
//   Handshake:
//     load_ready = (state!=LOAD).
//     Accept = load_valid & load_ready at a posedge; that edge registers ld = min(load_data, modulus).
//     No count toggle occurs at the accept edge; load takes priority over counting.
//     LOAD cycle: t_vec = q ^ ld, so q==ld after the next edge (load latency 2 edges from accept).
//     busy=1 and load_ready=0 for exactly that one cycle.
//   COUNT, up (up_dn=1):
//     q>=M: t_vec=q, i.e. wrap to 0. This covers M lowered below the current q.
//     else: t_vec[0]=1, t_vec[i]=&q[i-1:0] (+1).
//   COUNT, down (up_dn=0):
//     q==0 or q>M: t_vec=q^M, i.e. go to M.
//     else: t_vec[0]=1, t_vec[i]=~|q[i-1:0] (-1).
//   tc = (state==COUNT) & en & (up_dn ? q>=M : q==0). Asserted in the cycle before a wrap.
//   Boundary cases:
//     M=0: q stays 0 and tc=1 every enabled COUNT cycle.
//     M=2^WIDTH-1: natural binary wrap.
//     up_dn or M changes take effect at the next edge; there is no pipeline.
//     en=0 during LOAD: the load still completes, then ->IDLE.
//     rst_n low mid-LOAD: the load is dropped and q=0 immediately.
//   All arithmetic is unsigned WIDTH-bit. No q value is ever produced outside 0..max(M, previous q).
// STRUCTURE
//   Package tff_ctrl_pkg:
//     typedef enum logic [1:0] {ST_IDLE=2'd0, ST_COUNT=2'd1, ST_LOAD=2'd2} tff_state_t
//     localparam DIR_UP=1'b1, DIR_DN=1'b0
//   Sub-module tff_cell: single T flip-flop (t, clk, rst_n, q), async active-low reset to 0.
//     Instantiated WIDTH times via generate.
//   The controller holds the FSM, load register, t_vec logic and tc. The cells hold the only copy of q.
// TESTING (WIDTH=4, clk period 10)
//   1. Up count: M=9, en=1, up_dn=1 from reset -> q 0,1,..,9,0,1. tc=1 only in cycles where q==9.
//   2. Down count: M=9, up_dn=0 from q=0 -> q 9,8,..,0,9. tc=1 in cycles where q==0.
//   3. Load: at q=3, load_valid=1 with load_data=6 -> ready drops one cycle, busy=1, q==6 two edges after accept.
//      load_data=14 with M=9 -> q==9.
//   4. Modulus shrink: counting up at q=7, set M=3 -> next q=0, then 1,2,3,0.
//      Counting down with q=7, M=3 -> next q=3.
//   5. Hold/degenerate: en=0 at q=5 -> q holds 5, state IDLE, tc=0.
//      M=0, en=1 -> q stays 0, tc=1 continuously.
//   6. Async reset: rst_n=0 mid-cycle during LOAD at q=5 -> q=0, busy=0, load_ready=1 before the next edge.
//      Counting resumes from 0 after release.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// Shared types for the T flip-flop counter controller: FSM state encoding and direction constants.
// No logic, no latency, no flow control of its own.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_LOAD  = 2'd2
    } tff_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/tff_counter_ctrl_if.sv
// Control/status bundle between the counter's driver (master) and the controller (slave).
// Purely wires; the load handshake is valid/ready with the controller owning load_ready.
interface tff_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] modulus;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;

    modport master (
        output en, up_dn, modulus, load_valid, load_data,
        input  load_ready, q, tc, busy
    );

    modport slave (
        input  en, up_dn, modulus, load_valid, load_data,
        output load_ready, q, tc, busy
    );
endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop: q flips on the rising edge whenever t is high.
// One-edge latency, async active-low reset to 0, no backpressure.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Mod-(M+1) up/down counter built from a bank of T flip-flops; count step is one edge, a load lands two edges after accept.
// load_ready drops for exactly the single LOAD cycle; loads win over counting at the accept edge.
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    tff_counter_ctrl_if.slave  bus
);

    tff_state_t       state_q;
    logic [WIDTH-1:0] ld_q;
    logic [WIDTH-1:0] ld_d;
    logic             busy_q;
    logic             rdy_q;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic             accept;
    logic             run;

    assign accept = bus.load_valid & rdy_q;
    // Loads are clamped so the counter never leaves 0..M through a load.
    assign ld_d   = (bus.load_data > bus.modulus) ? bus.modulus : bus.load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ld_q    <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else if (accept) begin
            state_q <= ST_LOAD;
            ld_q    <= ld_d;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= bus.en ? ST_COUNT : ST_IDLE;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end
    end

    // Toggle vector: a carry/borrow chain for +/-1, or q^target for wrap and load jumps.
    always_comb begin
        t_vec = '0;
        run   = 1'b1;
        if (!accept) begin
            case (state_q)
                ST_LOAD: t_vec = q ^ ld_q;
                ST_COUNT: begin
                    if (bus.en) begin
                        if (bus.up_dn == DIR_UP) begin
                            if (q >= bus.modulus) begin
                                t_vec = q;
                            end else begin
                                for (int i = 0; i < WIDTH; i++) begin
                                    t_vec[i] = run;
                                    run      = run & q[i];
                                end
                            end
                        end else begin
                            if ((q == '0) || (q > bus.modulus)) begin
                                t_vec = q ^ bus.modulus;
                            end else begin
                                for (int i = 0; i < WIDTH; i++) begin
                                    t_vec[i] = run;
                                    run      = run & ~q[i];
                                end
                            end
                        end
                    end
                end
                default: t_vec = '0;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_vec[i]),
            .q     (q[i])
        );
    end

    assign bus.q          = q;
    assign bus.busy       = busy_q;
    assign bus.load_ready = rdy_q;
    assign bus.tc         = (state_q == ST_COUNT) & bus.en &
                            ((bus.up_dn == DIR_UP) ? (q >= bus.modulus) : (q == '0));

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed-vector bench for tff_counter_ctrl (WIDTH=4); expected outputs are queued per stimulus cycle and checked at the falling edge.
module tb_tff_counter_ctrl;

    typedef struct {
        logic [3:0] q;
        logic       tc;
        logic       busy;
        logic       rdy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    exp_t exp_q[$];
    string name_q[$];

    tff_counter_ctrl_if #(.WIDTH(4)) bus ();

    tff_counter_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    // Monitor: every falling edge with a pending expectation is compared.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            chk({n, ".q"},          bus.q,                 e.q);
            chk({n, ".tc"},         {3'b0, bus.tc},        {3'b0, e.tc});
            chk({n, ".busy"},       {3'b0, bus.busy},      {3'b0, e.busy});
            chk({n, ".load_ready"}, {3'b0, bus.load_ready}, {3'b0, e.rdy});
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the outputs expected in that cycle.
    task automatic step(input string nm, input logic r, input logic e, input logic u,
                        input logic [3:0] m, input logic lv, input logic [3:0] ld,
                        input logic [3:0] eq, input logic etc, input logic eb, input logic er);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n          = r;
        bus.en         = e;
        bus.up_dn      = u;
        bus.modulus    = m;
        bus.load_valid = lv;
        bus.load_data  = ld;
        x.q    = eq;
        x.tc   = etc;
        x.busy = eb;
        x.rdy  = er;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    initial begin
        total          = 0;
        passed         = 0;
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.up_dn      = 1'b1;
        bus.modulus    = 4'd9;
        bus.load_valid = 1'b0;
        bus.load_data  = 4'd0;

        // reset state
        step("reset", 0, 0, 1, 9, 0, 0,  0, 0, 0, 1);
        step("idle",  1, 1, 1, 9, 0, 0,  0, 0, 0, 1);

        // 1: up count 0..9 then wrap
        for (int i = 0; i <= 9; i++)
            step("up", 1, 1, 1, 9, 0, 0, 4'(i), (i == 9), 0, 1);
        step("up_wrap0", 1, 1, 1, 9, 0, 0, 0, 0, 0, 1);
        step("up_wrap1", 1, 1, 1, 9, 0, 0, 1, 0, 0, 1);

        // 2: down count through 0 -> 9
        step("dn2",  1, 1, 0, 9, 0, 0, 2, 0, 0, 1);
        step("dn1",  1, 1, 0, 9, 0, 0, 1, 0, 0, 1);
        step("dn0",  1, 1, 0, 9, 0, 0, 0, 1, 0, 1);
        for (int i = 9; i >= 0; i--)
            step("dn", 1, 1, 0, 9, 0, 0, 4'(i), (i == 0), 0, 1);
        step("dn_wrap", 1, 1, 0, 9, 0, 0, 9, 0, 0, 1);

        // 3: loads
        step("up8",   1, 1, 1, 9, 0, 0, 8, 0, 0, 1);
        step("up9",   1, 1, 1, 9, 0, 0, 9, 1, 0, 1);
        step("up0",   1, 1, 1, 9, 0, 0, 0, 0, 0, 1);
        step("up1",   1, 1, 1, 9, 0, 0, 1, 0, 0, 1);
        step("up2",   1, 1, 1, 9, 0, 0, 2, 0, 0, 1);
        step("ld6_req",  1, 1, 1, 9, 1, 6,  3, 0, 0, 1);
        step("ld6_busy", 1, 1, 1, 9, 0, 0,  3, 0, 1, 0);
        step("ld6_done", 1, 1, 1, 9, 0, 0,  6, 0, 0, 1);
        step("ld14_req", 1, 1, 1, 9, 1, 14, 7, 0, 0, 1);
        step("ld14_busy",1, 1, 1, 9, 0, 0,  7, 0, 1, 0);
        step("ld14_done",1, 1, 1, 9, 0, 0,  9, 1, 0, 1);
        step("post_ld",  1, 1, 1, 9, 0, 0,  0, 0, 0, 1);

        // 4: modulus shrink, up then down
        for (int i = 1; i <= 6; i++)
            step("up_pre", 1, 1, 1, 9, 0, 0, 4'(i), 0, 0, 1);
        step("shrink_q7", 1, 1, 1, 3, 0, 0, 7, 1, 0, 1);
        step("shrink_0",  1, 1, 1, 3, 0, 0, 0, 0, 0, 1);
        step("shrink_1",  1, 1, 1, 3, 0, 0, 1, 0, 0, 1);
        step("shrink_2",  1, 1, 1, 3, 0, 0, 2, 0, 0, 1);
        step("shrink_3",  1, 1, 1, 3, 0, 0, 3, 1, 0, 1);
        step("ld7_req",   1, 1, 1, 9, 1, 7, 0, 0, 0, 1);
        step("ld7_busy",  1, 1, 0, 3, 0, 0, 0, 0, 1, 0);
        step("dn_q7_m3",  1, 1, 0, 3, 0, 0, 7, 0, 0, 1);
        step("dn_to_m",   1, 1, 0, 3, 0, 0, 3, 0, 0, 1);

        // 5: hold with en=0, then M=0
        step("up_q2",  1, 1, 1, 9, 0, 0, 2, 0, 0, 1);
        step("up_q3",  1, 1, 1, 9, 0, 0, 3, 0, 0, 1);
        step("up_q4",  1, 1, 1, 9, 0, 0, 4, 0, 0, 1);
        step("hold_a", 1, 0, 1, 9, 0, 0, 5, 0, 0, 1);
        step("hold_b", 1, 0, 1, 9, 0, 0, 5, 0, 0, 1);
        step("hold_c", 1, 0, 1, 9, 0, 0, 5, 0, 0, 1);
        step("m0_idle",1, 1, 1, 0, 0, 0, 5, 0, 0, 1);
        step("m0_q5",  1, 1, 1, 0, 0, 0, 5, 1, 0, 1);
        step("m0_a",   1, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        step("m0_b",   1, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        step("m0_dn_a",1, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        step("m0_dn_b",1, 1, 0, 0, 0, 0, 0, 1, 0, 1);

        // 6: async reset while in LOAD with q=5
        step("ld5_req",   1, 1, 1, 9, 1, 5, 0, 0, 0, 1);
        step("ld5_busy",  1, 1, 1, 9, 0, 0, 0, 0, 1, 0);
        step("ld2_req",   1, 1, 1, 9, 1, 2, 5, 0, 0, 1);
        step("rst_in_ld", 0, 1, 1, 9, 0, 0, 0, 0, 0, 1);
        step("rst_rel",   1, 1, 1, 9, 0, 0, 0, 0, 0, 1);
        step("resume0",   1, 1, 1, 9, 0, 0, 0, 0, 0, 1);
        step("resume1",   1, 1, 1, 9, 0, 0, 1, 0, 0, 1);
        step("resume2",   1, 1, 1, 9, 0, 0, 2, 0, 0, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
